// File: rtl/uart_rx_fifo.sv
// Oversampling serial receiver with built-in baud tick, FWFT word FIFO and sticky error flags.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          CLK,
  input  logic                          IN_PB_RESET,
  input  logic                          IN_SERIAL_RX,
  input  logic                          IN_READ,
  input  logic                          IN_CLEAR_ERR,
  output logic [DATA_BITS-1:0]          OUT_DATA,
  output logic                          OUT_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   OUT_COUNT,
  output logic                          OUT_FRAME_ERR,
  output logic                          OUT_OVERRUN,
  output logic                          OUT_PARITY_ERR
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned BW      = $clog2(DATA_BITS);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic [TW-1:0]        tick_cnt_q;
  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rx;
  state_t               state_q;
  logic [SW-1:0]        samp_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 mid_sample;
  logic                 push;
  logic                 frame_set;
  logic                 par_set;

  assign tick = (tick_cnt_q == TW'(DIV - 1));
  assign rx   = sync_q[1];

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      tick_cnt_q <= '0;
      sync_q     <= '1;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      sync_q     <= {sync_q[0], IN_SERIAL_RX};
    end
  end

  // Word push and frame error are decided on the final stop mid-sample so the FIFO write lands on that edge.
  assign mid_sample = tick && (samp_q == SW'(OVERSAMPLE - 1));
  assign push       = mid_sample && (state_q == S_STOP) && rx && (stop_idx_q == 1'(STOP_BITS - 1));
  assign frame_set  = mid_sample && (state_q == S_STOP) && !rx;
`ifdef UART_RX_PARITY_EN
  assign par_set    = mid_sample && (state_q == S_PARITY) &&
                      (rx != ((^shift_q) ^ (PARITY_ODD != 0)));
`else
  assign par_set    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      state_q    <= S_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tick && !rx) begin
            state_q <= S_START;
            samp_q  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (samp_q == SW'(OVERSAMPLE / 2 - 1)) begin
              samp_q  <= '0;
              bit_q   <= '0;
              state_q <= rx ? S_IDLE : S_DATA;
            end else begin
              samp_q <= samp_q + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (mid_sample) begin
            samp_q  <= '0;
            shift_q <= {rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) begin
              stop_idx_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state_q    <= S_PARITY;
`else
              state_q    <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else if (tick) begin
            samp_q <= samp_q + SW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (mid_sample) begin
            samp_q  <= '0;
            state_q <= S_STOP;
          end else if (tick) begin
            samp_q <= samp_q + SW'(1);
          end
        end
`endif
        S_STOP: begin
          if (mid_sample) begin
            samp_q <= '0;
            if (!rx) begin
              state_q <= S_WAIT_HIGH;
            end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              state_q <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else if (tick) begin
            samp_q <= samp_q + SW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (tick && rx) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d, count;
  logic                 full, empty, do_pop, do_push;
  logic                 frame_q, frame_d, ovr_q, ovr_d, par_q, par_d;

  assign count   = wr_q - rd_q;
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = IN_READ && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    par_d   = par_q;
    if (do_push) wr_d = wr_q + (AW + 1)'(1);
    if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
    if (IN_CLEAR_ERR) begin
      frame_d = 1'b0;
      ovr_d   = 1'b0;
      par_d   = 1'b0;
    end
    if (frame_set)                     frame_d = 1'b1;
    if (push && full && !IN_READ)      ovr_d   = 1'b1;
    if (par_set)                       par_d   = 1'b1;
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      wr_q    <= '0;
      rd_q    <= '0;
      frame_q <= 1'b0;
      ovr_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      par_q   <= par_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= shift_q;
  end

  assign OUT_DATA      = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign OUT_VALID     = !empty;
  assign OUT_COUNT     = count;
  assign OUT_FRAME_ERR = frame_q;
  assign OUT_OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign OUT_PARITY_ERR = par_q;
`else
  assign OUT_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8-bit frames at 160 clocks/bit, FIFO depth 16.
module tb_uart_rx_fifo;
  localparam int unsigned BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n, rx, rd, clr;
  logic [7:0] dout;
  logic       valid, fe, ov, pe;
  logic [4:0] cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)
  ) dut (
    .CLK(clk), .IN_PB_RESET(rst_n), .IN_SERIAL_RX(rx), .IN_READ(rd),
    .IN_CLEAR_ERR(clr), .OUT_DATA(dout), .OUT_VALID(valid), .OUT_COUNT(cnt),
    .OUT_FRAME_ERR(fe), .OUT_OVERRUN(ov), .OUT_PARITY_ERR(pe)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_bits(input int unsigned nclk);
    repeat (nclk) @(negedge clk);
  endtask

  // Line is left at the stop level; expected word is queued only for a clean frame that should fit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit bad_par, input bit expect_push);
    if (stop_ok && expect_push) sb_q.push_back(d);
    rx = 1'b0;
    wait_bits(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_bits(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    wait_bits(BIT_CLKS);
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
    rx = stop_ok;
    wait_bits(BIT_CLKS);
  endtask

  task automatic drain(input string tag);
    int unsigned guard = 0;
    while (valid && guard < 64) begin
      if (sb_q.size() == 0) chk({tag, "_extra"}, valid, 0);
      else                  chk({tag, "_data"}, dout, sb_q.pop_front());
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      guard++;
    end
    chk({tag, "_leftover"}, sb_q.size(), 0);
    chk({tag, "_cnt0"}, cnt, 0);
  endtask

  task automatic clear_err();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rx = 1'b1; rd = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_cnt",   cnt,   0);
    chk("rst_data",  dout,  0);
    chk("rst_flags", {fe, ov, pe}, 0);
    rst_n = 1'b1;
    wait_bits(5);

    send_frame(8'hA5, 1, 0, 1);
    chk("a5_valid", valid, 1);
    chk("a5_cnt",   cnt,   1);
    chk("a5_flags", {fe, ov, pe}, 0);
    drain("a5");
    chk("a5_valid0", valid, 0);

    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("rd_empty_cnt", cnt, 0);
    chk("rd_empty_valid", valid, 0);

    for (int i = 0; i < 17; i++) send_frame(8'(i), 1, 0, i < 16);
    chk("full_cnt", cnt, 16);
    chk("full_ovr", ov, 1);
    chk("full_fe",  fe, 0);
    drain("full");
    chk("ovr_sticky", ov, 1);
    clear_err();
    chk("ovr_clr", ov, 0);

    send_frame(8'h3C, 0, 0, 0);
    wait_bits(BIT_CLKS);
    rx = 1'b1;
    wait_bits(2 * BIT_CLKS);
    chk("fe_set", fe, 1);
    chk("fe_cnt", cnt, 0);
    send_frame(8'h55, 1, 0, 1);
    chk("fe_cnt1", cnt, 1);
    drain("fe");
    clear_err();
    chk("fe_clr", fe, 0);

    rx = 1'b0;
    wait_bits(40);
    rx = 1'b1;
    wait_bits(3 * BIT_CLKS);
    chk("glitch_cnt", cnt, 0);
    chk("glitch_flags", {fe, ov, pe}, 0);
    send_frame(8'h5A, 1, 0, 1);
    drain("post_glitch");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 1, 1);
    chk("par_bad", pe, 1);
    drain("par_bad");
    clear_err();
    chk("par_clr", pe, 0);
    send_frame(8'h07, 1, 0, 1);
    chk("par_good", pe, 0);
    drain("par_good");
`endif

    send_frame(8'h11, 1, 0, 1);
    send_frame(8'h22, 1, 0, 1);
    send_frame(8'h33, 1, 0, 1);
    chk("mid_cnt3", cnt, 3);
    rx = 1'b0;
    wait_bits(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0);
      wait_bits(BIT_CLKS);
    end
    rx = 1'b0;
    wait_bits(BIT_CLKS / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_cnt",   cnt,   0);
    chk("mid_rst_data",  dout,  0);
    chk("mid_rst_flags", {fe, ov, pe}, 0);
    sb_q.delete();
    @(negedge clk);
    rx = 1'b1;
    wait_bits(10);
    rst_n = 1'b1;
    wait_bits(BIT_CLKS);
    send_frame(8'h81, 1, 0, 1);
    chk("post_rst_cnt", cnt, 1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
